seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter N, default 32, data width; SHALL be legal for N >= 16, N even.
REQ-002 Port clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 Port rst  in  1  reset; it is synchronous and active-high.
REQ-004 Port start  in  1  accept request when busy=0.
REQ-005 Port op  in  3  000 ALU, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU; others illegal.
REQ-006 Port af  in  4  ALU function code, used when op=000.
REQ-007 Port i  in  1  immediate-form select, used when op=000.
REQ-008 Port a, b  in  N  operands.
REQ-009 Port busy  out  1  operation in progress.
REQ-010 Port done  out  1  one-cycle pulse when res/hi/lo/flags are valid.
REQ-011 Port res  out  N  registered ALU result.
REQ-012 Port ovf  out  1  signed overflow flag.
REQ-013 Port hi, lo  out  N  multiply/divide result registers.
REQ-014 Port divz  out  1  divide-by-zero flag.

Function
REQ-015 FSM states IDLE, ALU, MUL, DIV, FIN; start with busy=0 SHALL latch a, b, op, af, i.
REQ-016 start while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-017 ALU op: IDLE->ALU->IDLE; res/ovf SHALL update and done SHALL pulse on the edge after start (latency 1); busy SHALL be 0 throughout.
REQ-018 af: 0000 add, 0001 addu, 0010 sub, 0011 subu, 0100 and, 0101 or, 0110 xor, 0111 nor (i=0) / {b[15:0], N-16 zeros} (i=1), 1000 sll, 1001 srl, 1100 sra (shift amount b[log2N-1:0] applied to a), 1010 slt, 1011 sltu; other codes SHALL give res=0.
REQ-019 ovf SHALL be 1 only for af 0000/0010 with signed overflow; otherwise 0; it is updated only by ALU ops.
REQ-020 MUL: iterative shift-add on operand magnitudes, N iterations, then FIN applies the sign; done SHALL pulse N+1 cycles after start and busy SHALL be 1 in between.
REQ-021 MULT/MULTU: {hi,lo} SHALL equal the full 2N-bit product, signed or unsigned respectively.
REQ-022 DIV/DIVU: restoring division, same N+1 latency; lo = quotient truncated toward zero, hi = remainder with the dividend's sign.
REQ-023 Signed -2^(N-1) / -1 SHALL give lo=-2^(N-1), hi=0, with no flag.
REQ-024 b=0 on DIV/DIVU SHALL complete in 1 cycle with lo=all ones, hi=a, divz=1.
REQ-025 divz SHALL be cleared by any other accepted op.
REQ-026 Illegal op SHALL complete in 1 cycle with hi/lo/res unchanged and divz=0.
REQ-027 hi/lo SHALL change only at FIN or on a divide-by-zero completion.

Reset
REQ-028 rst SHALL take priority over start.
REQ-029 rst SHALL force IDLE and zero res, hi, lo, ovf, divz, done and busy on the next edge, including mid-operation; no done pulse SHALL be produced for an aborted op.

Configuration
REQ-030 Macro SEQ_ALU_DIV_EN defined: divider present, behaviour per REQ-022..025.
REQ-031 Macro SEQ_ALU_DIV_EN undefined: no divider logic; op 011/100 SHALL behave as illegal ops per REQ-026.

Structure
REQ-032 Package seq_alu_pkg SHALL hold the op encodings, af encodings and the FSM state enum.
REQ-033 Sub-module md_unit SHALL contain the iteration counter, partial-product/remainder registers and sign fix-up; seq_alu SHALL own the FSM, the combinational ALU and the output registers.

Verification (N=32)
REQ-034 ALU af=0000, a=0x7FFFFFFF, b=1 -> next edge: res=0x80000000, ovf=1, done=1.
REQ-035 MULT a=-3, b=5 -> done at cycle 33: hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy=1 for cycles 1-32.
REQ-036 DIV a=7, b=-2 -> lo=0xFFFFFFFD, hi=1; DIVU a=0x10, b=0 -> next edge: lo=0xFFFFFFFF, hi=0x10, divz=1.
REQ-037 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1; a second start at cycle 5 is ignored.
REQ-038 rst asserted at cycle 10 of MULT -> next edge: busy=0, hi=lo=0, and no done pulse.
REQ-039 SEQ_ALU_DIV_EN undefined, op=011 -> done after 1 cycle, hi/lo unchanged, divz=0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_pkg
// Description : Op / ALU-function encodings and FSM state type for seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    localparam logic [2:0] c_op_alu   = 3'b000;
    localparam logic [2:0] c_op_mult  = 3'b001;
    localparam logic [2:0] c_op_multu = 3'b010;
    localparam logic [2:0] c_op_div   = 3'b011;
    localparam logic [2:0] c_op_divu  = 3'b100;

    localparam logic [3:0] c_af_add  = 4'b0000;
    localparam logic [3:0] c_af_addu = 4'b0001;
    localparam logic [3:0] c_af_sub  = 4'b0010;
    localparam logic [3:0] c_af_subu = 4'b0011;
    localparam logic [3:0] c_af_and  = 4'b0100;
    localparam logic [3:0] c_af_or   = 4'b0101;
    localparam logic [3:0] c_af_xor  = 4'b0110;
    localparam logic [3:0] c_af_nor  = 4'b0111;
    localparam logic [3:0] c_af_sll  = 4'b1000;
    localparam logic [3:0] c_af_srl  = 4'b1001;
    localparam logic [3:0] c_af_slt  = 4'b1010;
    localparam logic [3:0] c_af_sltu = 4'b1011;
    localparam logic [3:0] c_af_sra  = 4'b1100;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_alu  = 3'd1;
    localparam logic [2:0] c_st_mul  = 3'd2;
    localparam logic [2:0] c_st_div  = 3'd3;
    localparam logic [2:0] c_st_fin  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = c_st_idle,
        ALU  = c_st_alu,
        MUL  = c_st_mul,
        DIV  = c_st_div,
        FIN  = c_st_fin
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Iterative shift-add multiplier / restoring divider on operand
//               magnitudes with sign fix-up. Divider built only with
//               SEQ_ALU_DIV_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
`ifdef SEQ_ALU_DIV_EN
    input  logic         i_div,
`endif
    input  logic         i_signed,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_last,
    output logic [N-1:0] o_hi,
    output logic [N-1:0] o_lo
);

    localparam int              c_cw   = $clog2(N);
    localparam logic [c_cw-1:0] c_last = c_cw'(N - 1);

    // Low half holds multiplier / quotient, high half product / remainder.
    logic [2*N-1:0]  r_acc;
    logic [N-1:0]    r_m;
    logic [c_cw-1:0] r_cnt;
    logic            r_run;
    logic            r_neg_q;

    logic [N-1:0]    w_ma;
    logic [N-1:0]    w_mb;
    logic [N:0]      w_sum;
    logic [2*N-1:0]  w_mul_nxt;
    logic [2*N-1:0]  w_acc_nxt;
    logic [2*N-1:0]  w_prod;

    assign w_ma      = (i_signed && i_a[N-1]) ? -i_a : i_a;
    assign w_mb      = (i_signed && i_b[N-1]) ? -i_b : i_b;
    assign w_sum     = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_m} : {(N+1){1'b0}});
    assign w_mul_nxt = {w_sum, r_acc[N-1:1]};
    assign o_last    = r_run && (r_cnt == c_last);

`ifdef SEQ_ALU_DIV_EN
    logic           r_div;
    logic           r_neg_r;
    logic [N:0]     w_sh;
    logic [N:0]     w_diff;
    logic [2*N-1:0] w_div_nxt;

    // Partial remainder stays below 2*divisor, so bit N of the difference is its sign.
    assign w_sh      = {r_acc[2*N-1:N], r_acc[N-1]};
    assign w_diff    = w_sh - {1'b0, r_m};
    assign w_div_nxt = w_diff[N] ? {w_sh[N-1:0],   r_acc[N-2:0], 1'b0}
                                 : {w_diff[N-1:0], r_acc[N-2:0], 1'b1};
    assign w_acc_nxt = r_div ? w_div_nxt : w_mul_nxt;
`else
    assign w_acc_nxt = w_mul_nxt;
`endif

    // Results are presented from the value the final iteration is about to write.
    always_comb begin
        w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
        o_hi   = w_prod[2*N-1:N];
        o_lo   = w_prod[N-1:0];
`ifdef SEQ_ALU_DIV_EN
        if (r_div) begin
            o_lo = r_neg_q ? -w_acc_nxt[N-1:0]   : w_acc_nxt[N-1:0];
            o_hi = r_neg_r ? -w_acc_nxt[2*N-1:N] : w_acc_nxt[2*N-1:N];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_neg_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            r_div   <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else if (i_load) begin
            r_acc   <= {{N{1'b0}}, w_ma};
            r_m     <= w_mb;
            r_cnt   <= '0;
            r_run   <= 1'b1;
            r_neg_q <= i_signed && (i_a[N-1] ^ i_b[N-1]);
`ifdef SEQ_ALU_DIV_EN
            r_div   <= i_div;
            r_neg_r <= i_signed && i_a[N-1];
`endif
        end else if (r_run) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (o_last) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU: 1-cycle ALU ops, N-iteration multiply/divide.
//               Divide ops are available only with SEQ_ALU_DIV_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [3:0]   af,
    input  logic         i,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] res,
    output logic         ovf,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         divz
);

    localparam int c_sw = $clog2(N);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_res;
    logic [N-1:0]   r_hi;
    logic [N-1:0]   r_lo;
    logic           r_ovf;
    logic           r_divz;

    logic           w_accept;
    logic           w_is_mul;
    logic           w_is_div;
    logic           w_divz_hit;
    logic           w_md_load;
    logic           w_md_signed;
    logic           w_md_last;
    logic [N-1:0]   w_md_hi;
    logic [N-1:0]   w_md_lo;
    logic [N-1:0]   w_alu;
    logic           w_ovf;
    logic [N-1:0]   w_sum;
    logic [N-1:0]   w_dif;
    logic [N-1:0]   w_lui;
    logic [c_sw-1:0] w_sh;

    // ALU and FIN are single-cycle completion states; they accept new work like IDLE.
    assign busy = (r_state == MUL) || (r_state == DIV);
    assign done = (r_state == ALU) || (r_state == FIN);
    assign res  = r_res;
    assign ovf  = r_ovf;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign divz = r_divz;

    assign w_accept    = start && !busy;
    assign w_is_mul    = (op == c_op_mult) || (op == c_op_multu);
`ifdef SEQ_ALU_DIV_EN
    assign w_is_div    = (op == c_op_div) || (op == c_op_divu);
`else
    assign w_is_div    = 1'b0;
`endif
    assign w_divz_hit  = w_is_div && (b == '0);
    assign w_md_load   = w_accept && (w_is_mul || (w_is_div && !w_divz_hit));
    assign w_md_signed = (op == c_op_mult) || (op == c_op_div);

    md_unit #(
        .N        (N)
    ) u_md_unit (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_md_load),
`ifdef SEQ_ALU_DIV_EN
        .i_div    (w_is_div),
`endif
        .i_signed (w_md_signed),
        .i_a      (a),
        .i_b      (b),
        .o_last   (w_md_last),
        .o_hi     (w_md_hi),
        .o_lo     (w_md_lo)
    );

    always_comb begin
        w_sh  = b[c_sw-1:0];
        w_sum = a + b;
        w_dif = a - b;
        w_lui = '0;
        w_lui[15:0] = b[15:0];
        w_lui = w_lui << (N - 16);
        w_alu = '0;
        w_ovf = 1'b0;
        case (af)
            c_af_add: begin
                w_alu = w_sum;
                w_ovf = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
            end
            c_af_addu: w_alu = w_sum;
            c_af_sub: begin
                w_alu = w_dif;
                w_ovf = (a[N-1] != b[N-1]) && (w_dif[N-1] != a[N-1]);
            end
            c_af_subu: w_alu = w_dif;
            c_af_and:  w_alu = a & b;
            c_af_or:   w_alu = a | b;
            c_af_xor:  w_alu = a ^ b;
            c_af_nor:  w_alu = i ? w_lui : ~(a | b);
            c_af_sll:  w_alu = a << w_sh;
            c_af_srl:  w_alu = a >> w_sh;
            c_af_sra:  w_alu = $signed(a) >>> w_sh;
            c_af_slt:  w_alu = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            c_af_sltu: w_alu = {{(N-1){1'b0}}, (a < b)};
            default:   w_alu = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MUL, DIV: begin
                if (w_md_last) begin
                    w_state_nxt = FIN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                if (w_accept) begin
                    if (op == c_op_alu) begin
                        w_state_nxt = ALU;
                    end else if (w_is_mul) begin
                        w_state_nxt = MUL;
                    end else if (w_is_div && !w_divz_hit) begin
                        w_state_nxt = DIV;
                    end else begin
                        w_state_nxt = FIN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_res   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_ovf   <= 1'b0;
            r_divz  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_divz <= 1'b0;
                if (op == c_op_alu) begin
                    r_res <= w_alu;
                    r_ovf <= w_ovf;
                end else if (w_divz_hit) begin
                    r_lo   <= '1;
                    r_hi   <= a;
                    r_divz <= 1'b1;
                end
            end
            if (busy && w_md_last) begin
                r_hi <= w_md_hi;
                r_lo <= w_md_lo;
            end
        end
    end

endmodule
`default_nettype wire
